// File: rtl/ula_acc_ctrl.sv
// ula_acc_ctrl: accumulator, flags and instruction sequencer around the
// combinational Neander ULA. It takes one instruction at a time, steers the
// ULA from the latched opcode and writes the result back at the end of EXEC.
module ula_acc_ctrl #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_operand,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_sel,
  output logic             alu_sub,
  input  logic [WIDTH-1:0] alu_f,
  input  logic             alu_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [WIDTH-1:0] acc,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             halted
);

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_LDA = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_STA = 3'b100;
  localparam logic [2:0] OP_CLR = 3'b110;
  localparam logic [2:0] OP_HLT = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    OUT,
    HALT
  } state_t;

  state_t           state;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] operand_q;

  // Ready only in IDLE, and never while reset is being held.
  assign in_ready = rst_n && (state == IDLE);
  assign alu_a    = acc;
  assign alu_b    = operand_q;

  // ULA steering decoded from the latched opcode.
  always_comb begin
    alu_sel = 2'b00;
    alu_sub = 1'b0;
    case (op_q)
      OP_LDA: alu_sel = 2'b01;
      OP_ADD: alu_sel = 2'b10;
      OP_SUB: begin
        alu_sel = 2'b10;
        alu_sub = 1'b1;
      end
      default: begin
        alu_sel = 2'b00;
        alu_sub = 1'b0;
      end
    endcase
  end

  // Sequencer: latch the instruction, write back ULA results, run the output handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_q      <= OP_NOP;
      operand_q <= '0;
      acc       <= '0;
      flag_n    <= 1'b0;
      flag_z    <= 1'b1;
      flag_c    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      halted    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_q      <= in_op;
            operand_q <= in_operand;
            state     <= EXEC;
          end
        end
        EXEC: begin
          case (op_q)
            OP_LDA: begin
              acc    <= alu_f;
              flag_n <= alu_f[WIDTH-1];
              flag_z <= (alu_f == '0);
            end
            OP_ADD, OP_SUB: begin
              acc    <= alu_f;
              flag_n <= alu_f[WIDTH-1];
              flag_z <= (alu_f == '0);
              flag_c <= alu_cout;
            end
            OP_CLR: begin
              acc    <= '0;
              flag_n <= 1'b0;
              flag_z <= 1'b1;
              flag_c <= 1'b0;
            end
            default: begin
              acc <= acc;
            end
          endcase
          case (op_q)
            OP_STA: begin
              out_valid <= 1'b1;
              out_data  <= acc;
              state     <= OUT;
            end
            OP_HLT: begin
              halted <= 1'b1;
              state  <= HALT;
            end
            default: state <= IDLE;
          endcase
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_acc_ctrl.sv
// tb_ula_acc_ctrl: table-driven vectors, hand-written corner sequences and a
// randomized run against an arithmetic reference model. The ULA is modelled
// here as plain combinational logic around the DUT.
module tb_ula_acc_ctrl;

  localparam int WIDTH = 3;
  localparam int MOD   = 1 << WIDTH;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_LDA = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_STA = 3'b100;
  localparam logic [2:0] OP_RSV = 3'b101;
  localparam logic [2:0] OP_CLR = 3'b110;
  localparam logic [2:0] OP_HLT = 3'b111;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [WIDTH-1:0] in_operand;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [1:0]       alu_sel;
  logic             alu_sub;
  logic [WIDTH-1:0] alu_f;
  logic             alu_cout;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [WIDTH-1:0] acc;
  logic             flag_n;
  logic             flag_z;
  logic             flag_c;
  logic             halted;

  int checks = 0;
  int errors = 0;

  int m_acc;
  int m_n;
  int m_z;
  int m_c;

  typedef struct {
    logic [2:0] op;
    logic [2:0] operand;
    logic [2:0] acc;
    logic       n;
    logic       z;
    logic       c;
  } vec_t;

  vec_t vecs[13];

  ula_acc_ctrl #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_operand (in_operand),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_sub    (alu_sub),
    .alu_f      (alu_f),
    .alu_cout   (alu_cout),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .acc        (acc),
    .flag_n     (flag_n),
    .flag_z     (flag_z),
    .flag_c     (flag_c),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  // Neander ULA stand-in: pass a, pass b, or a +/- b with raw carry out.
  logic [WIDTH-1:0] ula_bx;
  logic [WIDTH:0]   ula_sum;
  always_comb begin
    ula_bx   = alu_sub ? ~alu_b : alu_b;
    ula_sum  = {1'b0, alu_a} + {1'b0, ula_bx} + {{WIDTH{1'b0}}, alu_sub};
    alu_cout = ula_sum[WIDTH];
    case (alu_sel)
      2'b00:   alu_f = alu_a;
      2'b01:   alu_f = alu_b;
      2'b10:   alu_f = ula_sum[WIDTH-1:0];
      default: alu_f = '0;
    endcase
  end

  // Hard stop in case something wedges the bench itself.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic int expSel(input logic [2:0] op);
    if (op == OP_LDA) return 1;
    if (op == OP_ADD || op == OP_SUB) return 2;
    return 0;
  endfunction

  task automatic modelReset();
    m_acc = 0;
    m_n   = 0;
    m_z   = 1;
    m_c   = 0;
  endtask

  task automatic modelExec(input logic [2:0] op, input logic [2:0] operand);
    int b;
    int s;
    b = int'(operand);
    case (op)
      OP_LDA: m_acc = b;
      OP_ADD: begin
        s     = m_acc + b;
        m_c   = (s >= MOD) ? 1 : 0;
        m_acc = s % MOD;
      end
      OP_SUB: begin
        m_c   = (m_acc >= b) ? 1 : 0;
        m_acc = (m_acc - b + MOD) % MOD;
      end
      OP_CLR: begin
        m_acc = 0;
        m_c   = 0;
      end
      default: m_acc = m_acc;
    endcase
    if (op == OP_LDA || op == OP_ADD || op == OP_SUB || op == OP_CLR) begin
      m_n = (m_acc >= MOD / 2) ? 1 : 0;
      m_z = (m_acc == 0) ? 1 : 0;
    end
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, " acc"}, acc, m_acc);
    checkOutput({tag, " flag_n"}, flag_n, m_n);
    checkOutput({tag, " flag_z"}, flag_z, m_z);
    checkOutput({tag, " flag_c"}, flag_c, m_c);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    checkOutput("in_ready low during reset", in_ready, 0);
    tick();
    rst_n = 1'b1;
    modelReset();
    checkOutput("reset out_valid", out_valid, 0);
    checkOutput("reset out_data", out_data, 0);
    checkOutput("reset halted", halted, 0);
    checkOutput("reset alu_sel", alu_sel, 0);
    checkOutput("reset alu_sub", alu_sub, 0);
    checkModel("reset");
  endtask

  // One instruction through the input handshake, EXEC and (for STA) the output handshake.
  task automatic applyStimulus(input logic [2:0] op, input logic [2:0] operand, input int stall);
    int waited;
    waited = 0;
    while (!in_ready && waited < 20) begin
      tick();
      waited++;
    end
    checkOutput("in_ready before accept", in_ready, 1);
    if (in_ready !== 1'b1) return;
    in_valid   = 1'b1;
    in_op      = op;
    in_operand = operand;
    tick();
    in_valid   = 1'($urandom_range(0, 1));
    in_op      = 3'($urandom);
    in_operand = WIDTH'($urandom);
    checkOutput("in_ready in EXEC", in_ready, 0);
    checkOutput("alu_sel in EXEC", alu_sel, expSel(op));
    checkOutput("alu_sub in EXEC", alu_sub, (op == OP_SUB) ? 1 : 0);
    checkOutput("alu_b in EXEC", alu_b, operand);
    tick();
    in_valid = 1'b0;
    modelExec(op, operand);
    if (op == OP_STA) begin
      for (int i = 0; i < stall; i++) begin
        checkOutput("out_valid while stalled", out_valid, 1);
        checkOutput("out_data while stalled", out_data, m_acc);
        checkOutput("in_ready while stalled", in_ready, 0);
        in_op      = 3'($urandom);
        in_operand = WIDTH'($urandom);
        tick();
      end
      checkOutput("out_valid before handshake", out_valid, 1);
      checkOutput("out_data before handshake", out_data, m_acc);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checkOutput("out_valid after handshake", out_valid, 0);
      checkOutput("in_ready after handshake", in_ready, 1);
    end else if (op == OP_HLT) begin
      checkOutput("halted after HLT", halted, 1);
      checkOutput("in_ready after HLT", in_ready, 0);
    end else begin
      checkOutput("in_ready after EXEC", in_ready, 1);
      checkOutput("out_valid after EXEC", out_valid, 0);
    end
  endtask

  // Test sequence: table vectors, corner sequences, then randomized run.
  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_op      = OP_NOP;
    in_operand = '0;
    out_ready  = 1'b0;

    vecs[0]  = '{OP_LDA, 3'd3, 3'd3, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{OP_ADD, 3'd2, 3'd5, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{OP_LDA, 3'd6, 3'd6, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{OP_ADD, 3'd3, 3'd1, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{OP_SUB, 3'd1, 3'd0, 1'b0, 1'b1, 1'b1};
    vecs[5]  = '{OP_LDA, 3'd2, 3'd2, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{OP_SUB, 3'd3, 3'd7, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{OP_CLR, 3'd5, 3'd0, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{OP_LDA, 3'd7, 3'd7, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{OP_NOP, 3'd2, 3'd7, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{OP_RSV, 3'd4, 3'd7, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{OP_ADD, 3'd1, 3'd0, 1'b0, 1'b1, 1'b1};
    vecs[12] = '{OP_LDA, 3'd0, 3'd0, 1'b0, 1'b1, 1'b1};

    doReset();

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].op, vecs[i].operand, 0);
      checkOutput($sformatf("vec%0d acc", i), acc, vecs[i].acc);
      checkOutput($sformatf("vec%0d flag_n", i), flag_n, vecs[i].n);
      checkOutput($sformatf("vec%0d flag_z", i), flag_z, vecs[i].z);
      checkOutput($sformatf("vec%0d flag_c", i), flag_c, vecs[i].c);
    end

    // LDA 4 then STA held off for three cycles.
    applyStimulus(OP_LDA, 3'd4, 0);
    applyStimulus(OP_STA, 3'd1, 3);
    checkModel("after STA");
    checkOutput("STA acc held", acc, 4);

    // HLT ignores further instructions until reset.
    applyStimulus(OP_HLT, 3'd0, 0);
    in_valid   = 1'b1;
    in_op      = OP_ADD;
    in_operand = 3'd1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("halted holds", halted, 1);
      checkOutput("in_ready in HALT", in_ready, 0);
      checkOutput("acc in HALT", acc, 4);
    end
    doReset();

    // Reset in the EXEC cycle of ADD 5 cancels the ADD.
    applyStimulus(OP_LDA, 3'd3, 0);
    in_valid   = 1'b1;
    in_op      = OP_ADD;
    in_operand = 3'd5;
    tick();
    in_valid = 1'b0;
    checkOutput("EXEC before reset", in_ready, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    modelReset();
    checkModel("reset mid EXEC");
    tick();
    tick();
    checkModel("after reset mid EXEC");
    checkOutput("in_ready after reset mid EXEC", in_ready, 1);

    // Reset while out_ready is high in OUT.
    applyStimulus(OP_LDA, 3'd6, 0);
    in_valid = 1'b1;
    in_op    = OP_STA;
    tick();
    in_valid = 1'b0;
    tick();
    checkOutput("out_valid before reset", out_valid, 1);
    checkOutput("out_data before reset", out_data, 6);
    out_ready = 1'b1;
    rst_n     = 1'b0;
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b0;
    modelReset();
    checkOutput("out_valid reset mid OUT", out_valid, 0);
    checkOutput("out_data reset mid OUT", out_data, 0);
    checkModel("reset mid OUT");

    // Randomized instruction stream against the arithmetic model.
    for (int i = 0; i < 300; i++) begin
      logic [2:0] rop;
      logic [2:0] ropnd;
      rop   = 3'($urandom_range(0, 7));
      ropnd = 3'($urandom_range(0, 7));
      if (rop == OP_HLT && $urandom_range(0, 3) != 0) rop = OP_ADD;
      applyStimulus(rop, ropnd, $urandom_range(0, 3));
      checkModel($sformatf("rand%0d", i));
      if (rop == OP_HLT) doReset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
